// File: rtl/xpb_pkg.sv
// Shared constants and types for the XPB lookup sequencer.
// Optional build macro: XPB_SKIP_ZERO_EN (skip segments whose index is zero).
package xpb_pkg;

    localparam int NUM_SEGS  = 32;
    localparam int IDX_W     = 5;
    localparam int DATA_W    = 1024;
    localparam int SEG_W     = $clog2(NUM_SEGS);
    // Guard bits: NUM_SEGS words of DATA_W bits cannot exceed DATA_W+SEG_W bits.
    localparam int ACC_W     = DATA_W + SEG_W;
    localparam int IDX_VEC_W = NUM_SEGS * IDX_W;

    typedef logic [SEG_W-1:0] seg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/xpb_lookup_seq_if.sv
// Job request, ROM bank and result handshake of the XPB lookup sequencer.
// slave = the sequencer, master = the surrounding datapath / ROM bank.
interface xpb_lookup_seq_if
    import xpb_pkg::*;
();
    logic                 in_valid;
    logic                 in_ready;
    logic [IDX_VEC_W-1:0] in_idx;
    seg_t                 rom_seg;
    logic [IDX_W-1:0]     rom_idx;
    logic                 rom_en;
    logic [DATA_W-1:0]    rom_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_sum;

    modport slave (
        input  in_valid, in_idx, rom_data, out_ready,
        output in_ready, rom_seg, rom_idx, rom_en, out_valid, out_sum
    );

    modport master (
        output in_valid, in_idx, rom_data, out_ready,
        input  in_ready, rom_seg, rom_idx, rom_en, out_valid, out_sum
    );
endinterface

// File: rtl/xpb_next_seg.sv
// Finds the lowest segment at or above 'start' whose index is non-zero.
// Only instantiated when XPB_SKIP_ZERO_EN is defined.
module xpb_next_seg
    import xpb_pkg::*;
(
    input  logic [IDX_VEC_W-1:0] idx_vec,
    input  logic [SEG_W:0]       start,
    output logic                 found,
    output seg_t                 next_seg
);

    logic [NUM_SEGS-1:0] cand;

    // A segment is a candidate if its index is non-zero and not yet passed.
    generate
        for (genvar gi = 0; gi < NUM_SEGS; gi++) begin : g_cand
            assign cand[gi] = (idx_vec[gi*IDX_W +: IDX_W] != '0) &&
                              ((SEG_W+1)'(gi) >= start);
        end
    endgenerate

    // Priority encode: lowest candidate wins.
    always_comb begin
        found    = 1'b0;
        next_seg = '0;
        for (int s = NUM_SEGS - 1; s >= 0; s--) begin
            if (cand[s]) begin
                found    = 1'b1;
                next_seg = seg_t'(s);
            end
        end
    end

endmodule

// File: rtl/xpb_lookup_seq.sv
// XPB lookup sequencer: issues one segment index per cycle to the external
// registered ROM bank and accumulates the returned words into an exact sum.
// Optional build macro: XPB_SKIP_ZERO_EN -- zero-index segments are skipped.
module xpb_lookup_seq
    import xpb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    xpb_lookup_seq_if.slave  bus
);

    state_t               state_q, state_d;
    seg_t                 seg_q, seg_d;
    logic [IDX_VEC_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    // rom_en delayed by the ROM read latency; qualifies rom_data.
    logic                 rom_en_dly_q, rom_en_dly_d;

    logic [IDX_W-1:0]     idx_arr [NUM_SEGS];

    // Unpack the latched index vector so the issue mux is a plain array select.
    generate
        for (genvar gi = 0; gi < NUM_SEGS; gi++) begin : g_unpack
            assign idx_arr[gi] = idx_q[gi*IDX_W +: IDX_W];
        end
    endgenerate

`ifdef XPB_SKIP_ZERO_EN
    logic [IDX_VEC_W-1:0] enc_vec;
    logic [SEG_W:0]       enc_start;
    logic                 enc_found;
    seg_t                 enc_seg;

    // In IDLE search the incoming job from segment 0; in ISSUE search the
    // latched job from the segment after the one being issued now.
    assign enc_vec   = (state_q == IDLE) ? bus.in_idx : idx_q;
    assign enc_start = (state_q == IDLE) ? '0 : ({1'b0, seg_q} + (SEG_W+1)'(1));

    xpb_next_seg u_next_seg (
        .idx_vec  (enc_vec),
        .start    (enc_start),
        .found    (enc_found),
        .next_seg (enc_seg)
    );
`endif

    assign bus.out_sum = acc_q;

    // Next-state, issue outputs and accumulation.
    always_comb begin
        state_d       = state_q;
        seg_d         = seg_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.rom_en    = 1'b0;
        bus.rom_seg   = '0;
        bus.rom_idx   = '0;

        // ROM return from the previous cycle's issue.
        if (rom_en_dly_q) begin
            acc_d = acc_q + {{SEG_W{1'b0}}, bus.rom_data};
        end

        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    idx_d = bus.in_idx;
                    acc_d = '0;
`ifdef XPB_SKIP_ZERO_EN
                    seg_d   = enc_seg;
                    state_d = enc_found ? ISSUE : DONE;
`else
                    seg_d   = '0;
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                bus.rom_en  = 1'b1;
                bus.rom_seg = seg_q;
                bus.rom_idx = idx_arr[seg_q];
`ifdef XPB_SKIP_ZERO_EN
                if (enc_found) begin
                    seg_d = enc_seg;
                end else begin
                    state_d = DRAIN;
                end
`else
                if (seg_q == seg_t'(NUM_SEGS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    seg_d = seg_q + seg_t'(1);
                end
`endif
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                    seg_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rom_en_dly_d = bus.rom_en;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            seg_q        <= '0;
            idx_q        <= '0;
            acc_q        <= '0;
            rom_en_dly_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seg_q        <= seg_d;
            idx_q        <= idx_d;
            acc_q        <= acc_d;
            rom_en_dly_q <= rom_en_dly_d;
        end
    end

endmodule

// File: tb/tb_xpb_lookup_seq.sv
// Self-checking bench for xpb_lookup_seq with a registered per-segment ROM
// model and a reference sum computed directly from the ROM table.
// Honours XPB_SKIP_ZERO_EN for expected latency and issue sequence.
module tb_xpb_lookup_seq;
    import xpb_pkg::*;

    localparam int ROM_DEPTH = 1 << IDX_W;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    xpb_lookup_seq_if bus ();

    xpb_lookup_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] rom_tbl [NUM_SEGS][ROM_DEPTH];

    // Registered ROM bank; drives junk when not enabled so unqualified data would corrupt the sum.
    always @(posedge clk) begin : rom_model
        logic [DATA_W-1:0] junk;
        for (int k = 0; k < DATA_W / 32; k++) junk[k*32 +: 32] = $urandom;
        if (bus.rom_en) bus.rom_data <= rom_tbl[bus.rom_seg][bus.rom_idx];
        else            bus.rom_data <= junk;
    end

    task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (low 128 bits, %0d bits differ)",
                     tag, obs[127:0], exp[127:0], $countones(obs ^ exp));
        end
    endtask

    function automatic logic [ACC_W-1:0] model_sum(input logic [IDX_VEC_W-1:0] v);
        logic [ACC_W-1:0] s;
        s = '0;
        for (int k = 0; k < NUM_SEGS; k++) s = s + ACC_W'(rom_tbl[k][v[k*IDX_W +: IDX_W]]);
        return s;
    endfunction

    function automatic logic [IDX_VEC_W-1:0] rand_vec(input bit allow_zero);
        logic [IDX_VEC_W-1:0] v;
        for (int k = 0; k < NUM_SEGS; k++) begin
            if (allow_zero && $urandom_range(0, 3) == 0) v[k*IDX_W +: IDX_W] = '0;
            else v[k*IDX_W +: IDX_W] = IDX_W'($urandom_range(1, ROM_DEPTH - 1));
        end
        return v;
    endfunction

    // Runs one job starting at a negedge with the sequencer expected idle;
    // returns at the negedge of the cycle following the output handshake.
    task automatic run_job(input string tag, input logic [IDX_VEC_W-1:0] v, input int stall);
        logic [ACC_W-1:0] exp_sum;
        logic [IDX_W-1:0] iv;
        int exp_q[$];
        int exp_lat, n_exp, nz, lat, issued, bad_issue, bad_hold, e;
        exp_sum = model_sum(v);
        nz = 0;
        for (int k = 0; k < NUM_SEGS; k++) begin
            iv = v[k*IDX_W +: IDX_W];
            if (iv != '0) nz++;
`ifdef XPB_SKIP_ZERO_EN
            if (iv != '0) exp_q.push_back(k);
`else
            exp_q.push_back(k);
`endif
        end
`ifdef XPB_SKIP_ZERO_EN
        exp_lat = (nz == 0) ? 1 : nz + 2;
`else
        exp_lat = NUM_SEGS + 2;
`endif
        n_exp = exp_q.size();

        chk({tag, "/in_ready"}, ACC_W'(bus.in_ready), ACC_W'(1));
        bus.in_idx    = v;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_idx   = rand_vec(1'b1);

        lat = 0; issued = 0; bad_issue = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (bus.rom_en) begin
                issued++;
                if (exp_q.size() == 0) bad_issue++;
                else begin
                    e = exp_q.pop_front();
                    if (bus.rom_seg != seg_t'(e) || bus.rom_idx != v[e*IDX_W +: IDX_W]) bad_issue++;
                end
            end
            if (bus.out_valid || lat > 200) break;
        end
        chk({tag, "/latency"}, ACC_W'(lat), ACC_W'(exp_lat));
        chk({tag, "/rom_en_count"}, ACC_W'(issued), ACC_W'(n_exp));
        chk({tag, "/issue_order"}, ACC_W'(bad_issue), '0);
        chk({tag, "/out_sum"}, bus.out_sum, exp_sum);

        bad_hold = 0;
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.in_idx   = rand_vec(1'b0);
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_sum ||
                bus.rom_en !== 1'b0 || bus.in_ready !== 1'b0) bad_hold++;
        end
        if (stall > 0) chk({tag, "/hold"}, ACC_W'(bad_hold), '0);

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "/out_valid_drop"}, ACC_W'(bus.out_valid), '0);
    endtask

    initial begin : main
        logic [IDX_VEC_W-1:0] v;
        logic [DATA_W-1:0]    w;
        int                   lat;
        n_checks = 0;
        n_fail   = 0;

        for (int s = 0; s < NUM_SEGS; s++) begin
            for (int i = 0; i < ROM_DEPTH; i++) begin
                if (i == 0) w = '0;
                else if (i == ROM_DEPTH - 1) w = '1;
                else for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom;
                rom_tbl[s][i] = w;
            end
        end

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_idx    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset/in_ready", ACC_W'(bus.in_ready), ACC_W'(1));
        chk("reset/out_valid", ACC_W'(bus.out_valid), '0);
        chk("reset/rom_en", ACC_W'(bus.rom_en), '0);
        chk("reset/rom_seg", ACC_W'(bus.rom_seg), '0);
        chk("reset/rom_idx", ACC_W'(bus.rom_idx), '0);
        chk("reset/out_sum", bus.out_sum, '0);
        rst = 1'b0;
        @(negedge clk);

        v = {NUM_SEGS{5'b00001}};
        run_job("all_one", v, 0);

        v = '0;
        v[IDX_W-1:0] = 5'b11111;
        run_job("seg0_only", v, 0);

        run_job("b2b_a", rand_vec(1'b1), 0);
        run_job("b2b_b", rand_vec(1'b1), 0);

        run_job("stall10", rand_vec(1'b1), 10);

        v = '0;
        run_job("all_zero", v, 0);

        // Abort a job in flight at segment 12.
        bus.in_idx   = rand_vec(1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!(bus.rom_en && bus.rom_seg == seg_t'(12)) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("abort/reach_seg12", ACC_W'(bus.rom_en && bus.rom_seg == seg_t'(12)), ACC_W'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("abort/in_ready", ACC_W'(bus.in_ready), ACC_W'(1));
        chk("abort/out_valid", ACC_W'(bus.out_valid), '0);
        chk("abort/rom_en", ACC_W'(bus.rom_en), '0);
        chk("abort/out_sum", bus.out_sum, '0);
        rst = 1'b0;
        @(negedge clk);
        run_job("post_abort", rand_vec(1'b1), 0);

        v = {NUM_SEGS{5'b11111}};
        run_job("max", v, 0);

        for (int j = 0; j < 1000; j++) begin
            run_job($sformatf("rand%0d", j), rand_vec(1'b1), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
